// File: rtl/seq_deser_pkg.sv
// Shared constants and types for the 4-lane serial-to-parallel deserializer.
// Lane count and lane-index width live here so the counter and top agree.
package seq_deser_pkg;

    localparam int LANES = 4;

    typedef logic [$clog2(LANES)-1:0] lane_idx_t;

    localparam lane_idx_t LAST_LANE = lane_idx_t'(LANES - 1);

endpackage

// File: rtl/seq_deser_4x2b_if.sv
// Upstream beat handshake plus downstream assembled-word handshake.
// master drives beats and out_rdy; slave is the deserializer.
interface seq_deser_4x2b_if #(
    parameter int p_nbits = 2
);
    logic               in_val;
    logic               in_rdy;
    logic [p_nbits-1:0] in;
    logic               out_val;
    logic               out_rdy;
    logic [p_nbits-1:0] out0;
    logic [p_nbits-1:0] out1;
    logic [p_nbits-1:0] out2;
    logic [p_nbits-1:0] out3;

    modport master (
        output in_val, in, out_rdy,
        input  in_rdy, out_val, out0, out1, out2, out3
    );

    modport slave (
        input  in_val, in, out_rdy,
        output in_rdy, out_val, out0, out1, out2, out3
    );
endinterface

// File: rtl/seq_deser_ctr.sv
// Wrapping mod-LANES beat counter; advances once per accepted beat.
module seq_deser_ctr
    import seq_deser_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      en,
    output lane_idx_t cnt
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST_LANE) ? '0 : cnt + lane_idx_t'(1);
        end
    end

endmodule

// File: rtl/seq_deser_4x2b.sv
// Collects LANES serial beats into one parallel word with a single output
// register; the last-lane beat stalls only while that register is still full.
module seq_deser_4x2b
    import seq_deser_pkg::*;
#(
    parameter int p_nbits = 2
) (
    input logic               clk,
    input logic               reset,
    seq_deser_4x2b_if.slave   bus
);

    lane_idx_t                          cnt;
    logic [LANES-2:0][p_nbits-1:0]      stg;
    logic [LANES-1:0][p_nbits-1:0]      word_q;
    logic                               out_val_q;
    logic                               last_lane;
    logic                               in_xfer;
    logic                               out_xfer;

    assign last_lane = (cnt == LAST_LANE);
    // A full output register blocks only the beat that would overwrite it.
    assign bus.in_rdy = !last_lane || !out_val_q || bus.out_rdy;
    assign in_xfer    = bus.in_val && bus.in_rdy;
    assign out_xfer   = out_val_q && bus.out_rdy;

    seq_deser_ctr u_ctr (
        .clk   (clk),
        .reset (reset),
        .en    (in_xfer),
        .cnt   (cnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stg <= '0;
        end else if (in_xfer) begin
            for (int i = 0; i < LANES - 1; i++) begin
                if (cnt == lane_idx_t'(i)) stg[i] <= bus.in;
            end
        end
    end

    // Load wins over drain so a same-cycle drain+load keeps out_val high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q    <= '0;
            out_val_q <= 1'b0;
        end else if (in_xfer && last_lane) begin
            word_q    <= {bus.in, stg};
            out_val_q <= 1'b1;
        end else if (out_xfer) begin
            out_val_q <= 1'b0;
        end
    end

    assign bus.out_val = out_val_q;
    assign bus.out0    = word_q[0];
    assign bus.out1    = word_q[1];
    assign bus.out2    = word_q[2];
    assign bus.out3    = word_q[3];

endmodule

// File: doc/seq_deser_4x2b.md
SEQ_DESER_4X2B -- requirements
Module: seq_deser_4x2b

Interface
REQ-001: Parameter p_nbits, default 2, lane width in bits; all lane ports and registers SHALL be p_nbits wide.
REQ-002: clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003: reset  input  1  asynchronous, active-low reset; reset==0 SHALL clear state immediately, independent of clk.
REQ-004: in_val  input  1  upstream beat valid.
REQ-005: in_rdy  output  1  upstream beat ready.
REQ-006: in  input  p_nbits  serial lane data; lane 0 first, lane 3 last.
REQ-007: out_val  output  1  assembled word valid.
REQ-008: out_rdy  input  1  downstream ready.
REQ-009: out0, out1, out2, out3  output  p_nbits each  assembled lanes 0..3.

Function
REQ-010: An input beat SHALL transfer only on a cycle with in_val && in_rdy; an output word SHALL transfer only on a cycle with out_val && out_rdy.
REQ-011: A 2-bit beat counter cnt SHALL track the next lane index 0..3, increment on each input transfer, and wrap from 3 to 0.
REQ-012: Input transfers at cnt 0, 1 and 2 SHALL write in into staging registers stg0, stg1 and stg2 respectively.
REQ-013: An input transfer at cnt 3 SHALL load out0..out3 with stg0, stg1, stg2 and in on the same edge, and SHALL set out_val.
REQ-014: Latency: out_val SHALL be 1 in the cycle immediately after the lane-3 beat transfers.
REQ-015: in_rdy SHALL be combinational: (cnt != 3) || !out_val || out_rdy.
REQ-016: Lanes 0..2 SHALL always be accepted, even while an output word is pending.
REQ-017: out_val and out0..out3 SHALL hold stable while out_val && !out_rdy (no overwrite, no drop).
REQ-018: On an output transfer with no simultaneous lane-3 input transfer, out_val SHALL clear on the next edge; out0..out3 SHALL retain their last values.
REQ-019: On an output transfer and a lane-3 input transfer in the same cycle, out0..out3 SHALL load the new word and out_val SHALL remain 1, giving a full throughput of one word per 4 cycles.
REQ-020: in_val low SHALL stall accumulation with cnt and staging registers unchanged; there is no timeout.
REQ-021: out_val SHALL NOT depend combinationally on out_rdy; in_rdy SHALL NOT depend on in_val.

Reset
REQ-022: While reset==0: cnt=0, stg0..stg2=0, out_val=0, out0..out3=0; in_rdy SHALL then evaluate to 1.
REQ-023: Reset asserted mid-word SHALL discard the partial word and any pending output word; the first beat after deassertion SHALL be treated as lane 0.

Structure
REQ-024: Shared package seq_deser_pkg SHALL hold the lane-count constant (4) and the lane-index typedef (2-bit).
REQ-025: The beat counter SHALL be one sub-module, seq_deser_ctr (wrapping mod-4 counter with enable), instantiated once; all other logic is flat.
REQ-026: The block SHALL contain no latches, and all flops SHALL share clk and reset.

Verification
REQ-027: Reset, then beats 0,1,2,3 with out_rdy=1 -> out_val=1 the cycle after the 4th beat; out0..out3 = 0,1,2,3.
REQ-028: Beats 3,0,1,2 then 2,3,0,1 back-to-back with out_rdy=1 -> words (3,0,1,2) and (2,3,0,1), out_val high exactly once per 4 cycles, no gaps.
REQ-029: out_rdy=0 after word (1,2,3,0) completes, then feed 4 more beats -> lanes 0..2 accepted, in_rdy=0 at lane 3, outputs hold (1,2,3,0); raise out_rdy -> (1,2,3,0) drains, then the stalled lane-3 beat loads the next word.
REQ-030: Beats 0,1 with in_val toggling 1,0,1, then reset=0 for 1 cycle, then beats 1,1,0,0 -> word (1,1,0,0); no residue from the pre-reset beats.
REQ-031: Reset asserted asynchronously between clock edges while out_val=1 -> out_val=0 and out0..out3=0 before the next posedge.
REQ-032: 20 random words with random in_val/out_rdy bubbles -> output word sequence equals a scoreboard model exactly, in order, with none lost or duplicated.
